// File: rtl/lut_cfg_pkg.sv
// Shared definitions for the LUT configuration-chain loader.
//   cfg_state_t  : loader FSM states
//   LUT5_BITS    : config bits of one LUT5 half
//   LUT6_2_BITS  : config bits of one LUT6_2 tile (two LUT5 halves)
//   cnt_width()  : width of a counter that must hold 0..n inclusive
package lut_cfg_pkg;

  typedef enum logic [1:0] {
    CFG_IDLE  = 2'd0,
    CFG_LOAD  = 2'd1,
    CFG_SHIFT = 2'd2,
    CFG_DONE  = 2'd3
  } cfg_state_t;

  localparam int LUT5_BITS   = 32;
  localparam int LUT6_2_BITS = 2 * LUT5_BITS;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lut_config_loader.sv
// Serialises WORD_W-bit configuration words, LSB first, into a bit-serial LUT
// config chain and assembles the bits falling out of the chain tail into
// read-back words.
//   config_clk/config_rst : clock, synchronous active-high reset
//   start                 : begin a session (honoured in IDLE/DONE only)
//   wr_data/valid/ready   : configuration word stream in
//   rd_data/valid/ready   : read-back word stream out (held until taken)
//   config_in/en/out      : chain head data, shift enable, chain tail data
//   busy/done             : session in progress / all CHAIN_LEN bits shifted
module lut_config_loader
  import lut_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = LUT6_2_BITS,
  parameter int WORD_W    = 8
) (
  input  logic              config_clk,
  input  logic              config_rst,
  input  logic              start,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              config_in,
  output logic              config_en,
  input  logic              config_out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = cnt_width(CHAIN_LEN);
  localparam int WL_W  = $clog2(WORD_W + 1);
  localparam int POS_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  cfg_state_t        state_q;
  logic [WORD_W-1:0] sreg_q;     // bits of the current word not yet presented
  logic [WORD_W-1:0] rdasm_q;    // read-back word under assembly
  logic [WORD_W-1:0] rd_data_q;
  logic [CNT_W-1:0]  bits_q;     // bits shifted into the chain this session
  logic [WL_W-1:0]   left_q;     // bits of the current word still to shift
  logic [POS_W-1:0]  pos_q;      // capture position inside rdasm_q
  logic              rd_valid_q, en_q, in_q, busy_q, done_q;

  logic              rd_valid_d;
  logic [WL_W-1:0]   left_load;
  logic [WORD_W-1:0] rdasm_cap;
  logic              word_last, next_last;
  logic [31:0]       remain;

  always_comb begin
    remain    = 32'(CHAIN_LEN) - 32'(bits_q);
    left_load = (remain < 32'(WORD_W)) ? WL_W'(remain) : WL_W'(WORD_W);
    // The tail bit is sampled at the shifting edge, i.e. the pre-shift bit.
    rdasm_cap        = rdasm_q;
    rdasm_cap[pos_q] = config_out;
    word_last  = (32'(left_q) == 32'd1);
    next_last  = (32'(left_q) == 32'd2);
    // Buffer state after this edge; a completion overwrites a word taken in
    // the same cycle, so it simply forces valid high.
    rd_valid_d = rd_valid_q & ~rd_ready;
    if (state_q == CFG_SHIFT && en_q && word_last) rd_valid_d = 1'b1;
  end

  always_ff @(posedge config_clk) begin
    if (config_rst) begin
      state_q    <= CFG_IDLE;
      sreg_q     <= '0;
      rdasm_q    <= '0;
      rd_data_q  <= '0;
      bits_q     <= '0;
      left_q     <= '0;
      pos_q      <= '0;
      rd_valid_q <= 1'b0;
      en_q       <= 1'b0;
      in_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      case (state_q)
        CFG_IDLE, CFG_DONE: begin
          if (start) begin
            state_q <= CFG_LOAD;
            bits_q  <= '0;
            rdasm_q <= '0;
            pos_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        CFG_LOAD: begin
          if (wr_valid) begin
            state_q <= CFG_SHIFT;
            in_q    <= wr_data[0];
            sreg_q  <= wr_data >> 1;
            left_q  <= left_load;
            // A one-bit word completes a read-back word on its only shift.
            en_q    <= !((32'(left_load) == 32'd1) && rd_valid_d);
          end
        end
        CFG_SHIFT: begin
          if (en_q) begin
            bits_q <= bits_q + CNT_W'(1);
            left_q <= left_q - WL_W'(1);
            if (word_last) begin
              rd_data_q <= rdasm_cap;
              rdasm_q   <= '0;
              pos_q     <= '0;
              en_q      <= 1'b0;
              if (32'(bits_q) + 32'd1 == 32'(CHAIN_LEN)) begin
                state_q <= CFG_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= CFG_LOAD;
              end
            end else begin
              rdasm_q <= rdasm_cap;
              pos_q   <= pos_q + POS_W'(1);
              in_q    <= sreg_q[0];
              sreg_q  <= sreg_q >> 1;
              // Hold off the word-completing shift while the buffer is full;
              // config_in already carries that bit and holds it.
              en_q    <= !(next_last && rd_valid_d);
            end
          end else if (!rd_valid_d) begin
            en_q <= 1'b1;
          end
        end
        default: state_q <= CFG_IDLE;
      endcase
    end
  end

  assign wr_ready  = (state_q == CFG_LOAD);
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign config_in = in_q;
  assign config_en = en_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_lut_config_loader.sv
// Directed/random bench for lut_config_loader: a 64-bit chain (8-bit words)
// and a 20-bit chain (partial last word), each driving a behavioural shift
// chain; expectations come from word concatenation and old-chain slicing.
module tb_lut_config_loader;
  localparam int NA = 64;
  localparam int NB = 20;
  localparam int W  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          a_start, a_wr_valid, a_wr_ready, a_rd_valid, a_rd_ready;
  logic          a_cin, a_cen, a_cout, a_busy, a_done, a_pre;
  logic [W-1:0]  a_wr_data, a_rd_data;
  logic [NA-1:0] a_chain, a_pre_val;

  logic          b_start, b_wr_valid, b_wr_ready, b_rd_valid, b_rd_ready;
  logic          b_cin, b_cen, b_cout, b_busy, b_done, b_pre;
  logic [W-1:0]  b_wr_data, b_rd_data;
  logic [NB-1:0] b_chain, b_pre_val;

  lut_config_loader #(.CHAIN_LEN(NA), .WORD_W(W)) dut_a (
    .config_clk(clk), .config_rst(rst), .start(a_start),
    .wr_data(a_wr_data), .wr_valid(a_wr_valid), .wr_ready(a_wr_ready),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rd_ready(a_rd_ready),
    .config_in(a_cin), .config_en(a_cen), .config_out(a_cout),
    .busy(a_busy), .done(a_done));

  lut_config_loader #(.CHAIN_LEN(NB), .WORD_W(W)) dut_b (
    .config_clk(clk), .config_rst(rst), .start(b_start),
    .wr_data(b_wr_data), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_ready(b_rd_ready),
    .config_in(b_cin), .config_en(b_cen), .config_out(b_cout),
    .busy(b_busy), .done(b_done));

  // Behavioural chains: config_in enters at the top, bit 0 is the tail.
  always @(posedge clk)
    if (a_pre) a_chain <= a_pre_val;
    else if (a_cen) a_chain <= {a_cin, a_chain[NA-1:1]};
  assign a_cout = a_chain[0];

  always @(posedge clk)
    if (b_pre) b_chain <= b_pre_val;
    else if (b_cen) b_chain <= {b_cin, b_chain[NB-1:1]};
  assign b_cout = b_chain[0];

  int errors = 0;
  int checks = 0;
  logic [W-1:0] a_words[$], b_words[$], a_rd[$], b_rd[$];
  logic         a_sent[$], b_sent[$];
  int a_widx, b_widx, a_en, b_en, a_hs, b_hs, a_ncyc;
  bit a_wrand, a_rrand;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: record what the next edge will do (sampled at negedge), then
  // update the stimulus 1 time unit after that edge.
  task automatic tick();
    bit a_acc, b_acc;
    @(negedge clk);
    a_acc = a_wr_valid && a_wr_ready;
    b_acc = b_wr_valid && b_wr_ready;
    if (a_cen) begin a_en++; a_sent.push_back(a_cin); end
    if (b_cen) begin b_en++; b_sent.push_back(b_cin); end
    if (a_rd_valid && a_rd_ready) a_rd.push_back(a_rd_data);
    if (b_rd_valid && b_rd_ready) b_rd.push_back(b_rd_data);
    @(posedge clk);
    #1;
    if (a_acc) begin
      a_hs++; a_widx++;
      a_wr_data = (a_widx < a_words.size()) ? a_words[a_widx] : '0;
    end
    if (b_acc) begin
      b_hs++; b_widx++;
      b_wr_data = (b_widx < b_words.size()) ? b_words[b_widx] : '0;
    end
    if (a_wrand) a_wr_valid = ($urandom_range(0, 9) < 7);
    if (a_rrand) a_rd_ready = ($urandom_range(0, 9) < 6);
  endtask

  // Chain after a full session: first bit in ends at the tail (bit 0).
  function automatic logic [NA-1:0] a_expect();
    logic [NA-1:0] c;
    logic [W-1:0]  w;
    c = '0;
    for (int i = 0; i < NA; i++) begin
      w = a_words[i / W];
      c[i] = w[i % W];
    end
    return c;
  endfunction

  task automatic a_begin(input logic [NA-1:0] pre);
    a_pre_val = pre; a_pre = 1'b1; tick(); a_pre = 1'b0;
    a_widx = 0; a_wr_data = a_words[0];
    a_en = 0; a_hs = 0; a_sent.delete(); a_rd.delete();
    a_start = 1'b1; tick(); a_start = 1'b0;
    a_ncyc = 1;
  endtask

  task automatic a_finish(input string tag);
    while (!a_done && a_ncyc < 2000) begin tick(); a_ncyc++; end
    chk({tag, "_done"}, 64'(a_done), 64'd1);
    chk({tag, "_busy_off"}, 64'(a_busy), 64'd0);
    a_wrand = 0; a_rrand = 0; a_rd_ready = 1'b1;
    for (int k = 0; k < 10 && a_rd_valid; k++) tick();
  endtask

  task automatic a_check(input string tag, input logic [NA-1:0] pre);
    chk({tag, "_en_cycles"}, 64'(a_en), 64'(NA));
    chk({tag, "_chain"}, 64'(a_chain), 64'(a_expect()));
    chk({tag, "_rd_count"}, 64'(a_rd.size()), 64'(NA / W));
    for (int i = 0; i < a_rd.size() && i < NA / W; i++)
      chk({tag, "_rd_word"}, 64'(a_rd[i]), 64'(pre[i*W +: W]));
  endtask

  initial begin
    logic [NA-1:0] pre;
    logic [NB-1:0] bpre;
    logic [W-1:0]  rw;
    int base, e0, v;
    bit pulsed;

    rst = 1'b1;
    a_start = 0; a_wr_valid = 0; a_rd_ready = 0; a_wr_data = '0; a_pre = 0; a_pre_val = '0;
    b_start = 0; b_wr_valid = 0; b_rd_ready = 0; b_wr_data = '0; b_pre = 0; b_pre_val = '0;
    repeat (3) tick();
    chk("rst_en", 64'(a_cen), 64'd0);
    chk("rst_in", 64'(a_cin), 64'd0);
    chk("rst_wr_ready", 64'(a_wr_ready), 64'd0);
    chk("rst_rd_valid", 64'(a_rd_valid), 64'd0);
    chk("rst_rd_data", 64'(a_rd_data), 64'd0);
    chk("rst_busy_done", {62'd0, a_busy, a_done}, 64'd0);
    rst = 1'b0;
    tick();

    // Full load of 0x00..0x07, no backpressure, random previous contents.
    a_words.delete();
    for (int i = 0; i < NA / W; i++) a_words.push_back(W'(i));
    pre = {$urandom, $urandom};
    a_wr_valid = 1; a_rd_ready = 1;
    a_begin(pre);
    a_finish("full");
    chk("full_session_cycles", 64'(a_ncyc), 64'(NA + NA / W + 1));
    chk("full_chain_const", 64'(a_chain), 64'h0706050403020100);
    a_check("full", pre);

    // Read-back of a known pattern while loading zeros.
    a_words.delete();
    for (int i = 0; i < NA / W; i++) a_words.push_back('0);
    pre = 64'hDEADBEEFCAFEF00D;
    a_wr_valid = 1; a_rd_ready = 1;
    a_begin(pre);
    a_finish("readback");
    a_check("readback", pre);
    chk("readback_chain_zero", 64'(a_chain), 64'd0);

    // Write stall in LOAD, then read backpressure from the first word on.
    a_words.delete();
    for (int i = 0; i < NA / W; i++) a_words.push_back(W'($urandom));
    pre = {$urandom, $urandom};
    a_wr_valid = 0; a_rd_ready = 0;
    a_begin(pre);
    for (int k = 0; k < 5; k++) begin
      tick(); a_ncyc++;
      chk("wstall_en", 64'(a_cen), 64'd0);
      chk("wstall_busy", 64'(a_busy), 64'd1);
    end
    chk("wstall_no_shift", 64'(a_en), 64'd0);
    a_wr_valid = 1;
    for (int k = 0; k < 100 && !a_rd_valid; k++) begin tick(); a_ncyc++; end
    chk("bp_first_word_valid", 64'(a_rd_valid), 64'd1);
    chk("bp_first_word_bits", 64'(a_en), 64'(W));
    base = a_en;
    repeat (30) begin tick(); a_ncyc++; end
    // With the first word unread, shifting continues up to, but not into,
    // the bit that would complete the second read-back word.
    chk("bp_extra_en", 64'(a_en - base), 64'(W - 1));
    chk("bp_en_held_low", 64'(a_cen), 64'd0);
    chk("bp_rd_held", 64'(a_rd_data), 64'(pre[W-1:0]));
    a_rrand = 1;
    a_finish("bp");
    a_check("bp", pre);

    // Random sessions with random write gaps and read backpressure.
    for (int s = 0; s < 3; s++) begin
      a_words.delete();
      for (int i = 0; i < NA / W; i++) a_words.push_back(W'($urandom));
      pre = {$urandom, $urandom};
      a_wr_valid = 0; a_rd_ready = 0; a_wrand = 1; a_rrand = 1;
      a_begin(pre);
      a_finish("rand");
      a_check("rand", pre);
    end

    // start ignored mid-session, then reset after 13 shifted bits.
    a_words.delete();
    for (int i = 0; i < NA / W; i++) a_words.push_back(W'($urandom));
    a_wr_valid = 1; a_rd_ready = 1;
    a_begin({$urandom, $urandom});
    pulsed = 0;
    for (int k = 0; k < 200 && a_en < 13; k++) begin
      a_start = (a_en == 5) && !pulsed;
      if (a_start) pulsed = 1;
      tick();
    end
    a_start = 0;
    chk("rst13_bits", 64'(a_en), 64'd13);
    chk("rst13_handshakes", 64'(a_hs), 64'd2);
    chk("rst13_busy", 64'(a_busy), 64'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst13_en", 64'(a_cen), 64'd0);
    chk("rst13_in", 64'(a_cin), 64'd0);
    chk("rst13_wr_ready", 64'(a_wr_ready), 64'd0);
    chk("rst13_rd", {55'd0, a_rd_valid, a_rd_data}, 64'd0);
    chk("rst13_busy_done", {62'd0, a_busy, a_done}, 64'd0);
    e0 = a_en;
    repeat (5) tick();
    chk("rst13_no_more_en", 64'(a_en - e0), 64'd0);
    chk("rst13_idle", {62'd0, a_busy, a_wr_ready}, 64'd0);

    // Partial final word on a 20-bit chain.
    b_words.delete();
    b_words.push_back(8'hFF); b_words.push_back(8'hFF); b_words.push_back(8'hAB);
    bpre = NB'($urandom);
    b_pre_val = bpre; b_pre = 1; tick(); b_pre = 0;
    b_widx = 0; b_wr_data = b_words[0]; b_en = 0; b_hs = 0;
    b_sent.delete(); b_rd.delete();
    b_wr_valid = 1; b_rd_ready = 1;
    b_start = 1; tick(); b_start = 0;
    for (int k = 0; k < 200 && !b_done; k++) tick();
    for (int k = 0; k < 10 && b_rd_valid; k++) tick();
    chk("part_done", 64'(b_done), 64'd1);
    chk("part_en_cycles", 64'(b_en), 64'(NB));
    v = 0;
    for (int i = 0; i < 4 && NB - 4 + i < b_sent.size(); i++)
      v = v | (int'(b_sent[NB - 4 + i]) << i);
    chk("part_last4", 64'(v), 64'hB);
    chk("part_chain", 64'(b_chain), 64'hBFFFF);
    chk("part_rd_count", 64'(b_rd.size()), 64'd3);
    if (b_rd.size() == 3) begin
      chk("part_rd0", 64'(b_rd[0]), 64'(bpre[7:0]));
      chk("part_rd1", 64'(b_rd[1]), 64'(bpre[15:8]));
      rw = b_rd[2];
      chk("part_rd2", 64'(rw), {60'd0, bpre[19:16]});
      chk("part_rd2_pad", 64'(rw[7:4]), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
